// File: rtl/sevenseg_scan_pkg.sv
// Shared constants and types for the stopwatch seven-segment scan stage.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package sevenseg_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  localparam logic [6:0] DIGIT_PAT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic {PhVisible, PhHidden} flash_phase_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal codes show a dash.
module bcd_to_7seg
  import sevenseg_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) seg = DIGIT_PAT[bcd];
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Four-digit common-anode display scanner with frame snapshot, leading-zero blank and flash.
// All outputs are registered; decode lags the scan index by one clock.
module sevenseg_scan
  import sevenseg_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned FLASH_SLOTS = 500,
  parameter int unsigned DP_DIGIT    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  input  logic       flash_en,
  input  logic       lead_blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FW = $clog2(FLASH_SLOTS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FLASH_MAX = FW'(FLASH_SLOTS - 1);
  localparam logic [1:0]    DP_IDX    = 2'(DP_DIGIT);

  logic [PW-1:0]     presc_q, presc_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0][3:0]   snap_q, snap_d;
  logic              first_q, first_d;
  logic              tick_q, tick_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  flash_phase_e      phase_q, phase_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic       slot_end, latch;
  logic       ghost, hidden, lead_hide;
  logic [6:0] dec_seg;

  assign slot_end = (presc_q == PRESC_MAX);
  // first_q forces one snapshot right after reset release so frame 0 is coherent
  assign latch    = first_q | (slot_end & (idx_q == 2'd3));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      first_q <= 1'b1;
      tick_q  <= 1'b0;
      fcnt_q  <= '0;
      phase_q <= PhVisible;
      an_q    <= ANODE_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      first_q <= first_d;
      tick_q  <= tick_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  always_comb begin
    presc_d = slot_end ? '0 : presc_q + 1'b1;
    idx_d   = slot_end ? idx_q + 2'd1 : idx_q;
    snap_d  = latch ? {digit3, digit2, digit1, digit0} : snap_q;
    first_d = 1'b0;
    tick_d  = latch;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (!flash_en) begin
      fcnt_d  = '0;
      phase_d = PhVisible;
    end else if (slot_end) begin
      if (fcnt_q == FLASH_MAX) begin
        fcnt_d  = '0;
        phase_d = (phase_q == PhVisible) ? PhHidden : PhVisible;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  bcd_to_7seg u_dec (
    .bcd (snap_q[idx_q]),
    .seg (dec_seg)
  );

  always_comb begin
    ghost     = (presc_q == '0);
    hidden    = (phase_q == PhHidden);
    lead_hide = lead_blank && (idx_q == 2'd3) && (snap_q[3] == 4'd0);
    an_d      = ANODE_OFF;
    if (!ghost && !hidden && !lead_hide) an_d[idx_q] = 1'b0;
    seg_d = lead_hide ? SEG_BLANK : dec_seg;
    dp_d  = !((idx_q == DP_IDX) && !hidden && !ghost);
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule
